// File: rtl/seq_det_sched_pkg.sv
// Shared constants for the round-robin scheduler in front of the serial 10001 detector.
package seq_det_sched_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_W     = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter
   import seq_det_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     found
);

   localparam int IW = $clog2(N_REQ);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one serial 10001 detector among N_REQ requesters: clear, shift a word MSB-first,
// count hits, return the count with a one-cycle ack.
module seq_det_scheduler
   import seq_det_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int W     = DEF_W
) (
   input  logic                     slowed_clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*W-1:0]       data,
   output logic [N_REQ-1:0]         ack,
   output logic [$clog2(W+1)-1:0]   hit_cnt,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     det_din,
   output logic                     det_rst,
   input  logic                     det_hit,
   output logic [2:0]               state
);

   // Handshake: a requester raises req[i] with data stable and holds it until ack[i] pulses
   // for one cycle; the word is captured at grant, so later data/req changes are ignored.

   localparam int CW = $clog2(W+1);
   localparam int IW = $clog2(N_REQ);
   localparam int KW = $clog2(W);

   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_found;
   logic [IW-1:0]    rr_ptr;
   logic [W-1:0]     word_sel;
   logic [W-1:0]     shreg;
   logic [KW-1:0]    bit_idx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    final_cnt;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .found (arb_found)
   );

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) word_sel = data[i*W +: W];
      end
   end

   // det_hit lags det_din by one cycle, so DRAIN still owes the last bit's hit.
   assign final_cnt = cnt + CW'(det_hit);

   assign busy    = (state != ST_IDLE);
   assign det_rst = reset | (state == ST_CLEAR);
   assign det_din = (state == ST_SHIFT) ? shreg[W-1] : 1'b0;

   always_ff @(posedge slowed_clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ack      <= '0;
         hit_cnt  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
         shreg    <= '0;
         bit_idx  <= '0;
         cnt      <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  shreg    <= word_sel;
                  grant_id <= arb_idx;
                  state    <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               cnt     <= '0;
               bit_idx <= '0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               shreg <= {shreg[W-2:0], 1'b0};
               if ((bit_idx != '0) && det_hit) cnt <= cnt + CW'(1);
               if (bit_idx == KW'(W-1)) state <= ST_DRAIN;
               else bit_idx <= bit_idx + KW'(1);
            end
            ST_DRAIN: begin
               hit_cnt <= final_cnt;
               ack     <= N_REQ'(1) << grant_id;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               rr_ptr <= (grant_id == IW'(N_REQ-1)) ? '0 : grant_id + IW'(1);
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler with a behavioural 10001 detector stub.
module tb_seq_det_scheduler;
   import seq_det_sched_pkg::*;

   localparam int N_REQ = 4;
   localparam int W     = 8;
   localparam int CW    = $clog2(W+1);
   localparam int IW    = $clog2(N_REQ);

   logic                 slowed_clk = 1'b0;
   logic                 reset      = 1'b1;
   logic [N_REQ-1:0]     req        = '0;
   logic [N_REQ*W-1:0]   data       = '0;
   logic [N_REQ-1:0]     ack;
   logic [CW-1:0]        hit_cnt;
   logic [IW-1:0]        grant_id;
   logic                 busy;
   logic                 det_din;
   logic                 det_rst;
   logic                 det_hit;
   logic [2:0]           state;

   int n_checks  = 0;
   int n_errors  = 0;
   int cyc       = 0;
   int ack_count = 0;
   logic [15:0] exp_q[$];
   int          ack_cyc[$];
   logic [2:0]  det_state = '0;

   always #5 slowed_clk = ~slowed_clk;

   seq_det_scheduler #(.N_REQ(N_REQ), .W(W)) dut (
      .slowed_clk (slowed_clk),
      .reset      (reset),
      .req        (req),
      .data       (data),
      .ack        (ack),
      .hit_cnt    (hit_cnt),
      .grant_id   (grant_id),
      .busy       (busy),
      .det_din    (det_din),
      .det_rst    (det_rst),
      .det_hit    (det_hit),
      .state      (state)
   );

   // Overlapping Moore 10001 detector; state 5 means the last five bits were 10001.
   always @(posedge slowed_clk) begin
      if (det_rst) det_state <= 3'd0;
      else if (det_din) det_state <= (det_state == 3'd4) ? 3'd5 : 3'd1;
      else begin
         case (det_state)
            3'd0:    det_state <= 3'd0;
            3'd1:    det_state <= 3'd2;
            3'd2:    det_state <= 3'd3;
            3'd3:    det_state <= 3'd4;
            3'd4:    det_state <= 3'd0;
            default: det_state <= 3'd2;
         endcase
      end
   end
   assign det_hit = (det_state == 3'd5);

   function automatic int ref_hits(input logic [W-1:0] w);
      int n = 0;
      for (int i = W-1; i >= 4; i--) begin
         if (w[i -: 5] == 5'b10001) n++;
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic handle_ack();
      logic [15:0] e;
      ack_count++;
      ack_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
         check("unexpected_ack", 32'(ack), 32'(0));
      end else begin
         e = exp_q.pop_front();
         check("ack_id", 32'(ack), 32'(1) << e[15:8]);
         check("hit_cnt", 32'(hit_cnt), 32'(e[7:0]));
      end
   endtask

   task automatic step();
      @(negedge slowed_clk);
      cyc++;
      if (|ack) handle_ack();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      data  = '0;
      repeat (3) step();
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_hit_cnt", 32'(hit_cnt), 32'(0));
      check("rst_grant_id", 32'(grant_id), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_det_din", 32'(det_din), 32'(0));
      check("rst_det_rst", 32'(det_rst), 32'(1));
      check("rst_state", 32'(state), 32'(ST_IDLE));
      reset = 1'b0;
      step();
   endtask

   task automatic run_single(input int id, input logic [W-1:0] word, input bit disturb);
      int busy_n = 0;
      int rst_n  = 0;
      data[id*W +: W] = word;
      req[id] = 1'b1;
      exp_q.push_back({8'(id), 8'(ref_hits(word))});
      for (int c = 1; c <= W+4; c++) begin
         step();
         if (busy) busy_n++;
         if (det_rst) rst_n++;
         if (c == 1) check("det_rst_clear", 32'(det_rst), 32'(1));
         if (c >= 2 && c <= W+1) check("det_din", 32'(det_din), 32'(word[W+1-c]));
         if (c == W+2) check("det_din_drain", 32'(det_din), 32'(0));
         if (disturb && c == 4) begin
            req[id] = 1'b0;
            data[id*W +: W] = ~word;
         end
         if (c == W+3) begin
            check("ack_latency", 32'(ack), 32'(1) << id);
            req[id] = 1'b0;
         end
         if (c == W+4) begin
            check("busy_after", 32'(busy), 32'(0));
            check("hit_hold", 32'(hit_cnt), 32'(ref_hits(word)));
         end
      end
      check("busy_cycles", 32'(busy_n), 32'(W+3));
      check("det_rst_cycles", 32'(rst_n), 32'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [W-1:0] words[N_REQ];

      do_reset();

      run_single(0, 8'b10001000, 1'b0);
      run_single(2, 8'hFF, 1'b0);
      run_single(0, 8'b00001000, 1'b0);
      run_single(1, 8'b10000000, 1'b0);
      run_single(3, 8'b10001011, 1'b1);
      for (int t = 0; t < 3; t++) begin
         run_single(int'($urandom_range(0, N_REQ-1)), W'($urandom_range(0, 255)), 1'b0);
      end

      // Reset in the fourth SHIFT cycle drops the word; a held req then restarts cleanly.
      data[1*W +: W] = 8'b10001000;
      req[1] = 1'b1;
      for (int c = 1; c <= 5; c++) step();
      check("pre_reset_state", 32'(state), 32'(ST_SHIFT));
      reset = 1'b1;
      step();
      check("mid_reset_state", 32'(state), 32'(ST_IDLE));
      check("mid_reset_busy", 32'(busy), 32'(0));
      check("mid_reset_ack", 32'(ack), 32'(0));
      reset = 1'b0;
      run_single(1, 8'b10001000, 1'b0);

      // All requesters pending: grants rotate 0,1,2,3,0 every W+4 cycles.
      do_reset();
      words[0] = 8'b00100011;
      words[1] = 8'b10001001;
      words[2] = 8'b11000110;
      words[3] = W'($urandom_range(0, 255));
      for (int i = 0; i < N_REQ; i++) data[i*W +: W] = words[i];
      for (int i = 0; i <= N_REQ; i++) begin
         exp_q.push_back({8'(i % N_REQ), 8'(ref_hits(words[i % N_REQ]))});
      end
      base = ack_count;
      ack_cyc.delete();
      req = '1;
      for (int c = 0; c < (N_REQ+1)*(W+4)+20 && ack_count < base+N_REQ+1; c++) step();
      req = '0;
      check("all_acks", 32'(ack_count - base), 32'(N_REQ+1));
      for (int i = 1; i <= N_REQ; i++) begin
         if (ack_cyc.size() > i) check("grant_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(W+4));
      end

      repeat (W+4) step();
      check("final_busy", 32'(busy), 32'(0));
      check("queue_empty", 32'(exp_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Round-robin scheduler that shares one serial 10001 sequence detector among N_REQ requesters. Each requester submits a W-bit word through a req/ack handshake. The block clears the detector, serializes the granted word MSB-first onto the detector's serial input, and counts detector hits. It returns the hit count to the requester with a one-cycle ack. It sits between requester logic and the detector, all in the slowed_clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, bits per submitted word (>=5)
CW, $clog2(W+1), hit-count width (derived, not overridden)

Ports:
slowed_clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
req  in  N_REQ  per-requester request level
data  in  N_REQ*W  word for requester i at data[i*W +: W]
ack  out  N_REQ  one-cycle completion pulse, one-hot
hit_cnt  out  CW  hits for the finishing word; valid when any ack bit is high
grant_id  out  $clog2(N_REQ)  index of the requester currently being served
busy  out  1  high in every state except IDLE
det_din  out  1  serial bit driven to the detector's data input
det_rst  out  1  detector synchronous reset
det_hit  in  1  detector Moore output (registered; reflects the bit driven one cycle earlier)

Behaviour:
- Reset: state=IDLE, ack=0, hit_cnt=0, grant_id=0, busy=0, det_din=0, rr pointer=0. det_rst = reset OR (state==CLEAR), combinational, so the detector clears together with this block.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req bit is high, pick the first requester with req set, searching from the rr pointer upward with wrap.
  - Latch that requester's data into a W-bit shift register, set grant_id, and go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR: one cycle, det_rst=1, det_din=0, hit counter cleared. Go to SHIFT with bit index k=0.
- SHIFT: W cycles, k=0..W-1.
  - det_din = latched word bit [W-1-k].
  - From k=1 onward, sample det_hit and increment the hit counter when it is high.
  - After k=W-1, go to DRAIN.
- DRAIN: one cycle, det_din=0. Sample det_hit for the last bit, then go to DONE.
- DONE: one cycle.
  - ack[grant_id]=1 and hit_cnt = final count.
  - rr pointer = grant_id+1 mod N_REQ.
  - Go to IDLE.
- Latency: from the IDLE cycle that grants to the ack cycle is W+3 cycles (W=8: ack 11 cycles after the grant cycle). The minimum request-to-request period is W+4 cycles.
- Handshake:
  - The requester holds req and data stable until it sees ack.
  - Data is captured at grant; changes to data after the grant are ignored.
  - If req drops mid-transaction, the transaction still completes and ack is still issued.
  - If req is still high in the cycle after ack, it is treated as a new request. Rotation gives other pending requesters priority first.
- Fairness: with all requesters pending, grants go in order 0,1,...,N_REQ-1,0,...
- Isolation: the CLEAR before every word guarantees that no hit spans two words.
- hit_cnt holds its value between acks. It is meaningful only while an ack bit is high.
- A reset in any state returns immediately to the reset values. The in-flight word is dropped and no ack is issued.
- Counter width: the maximum possible count is less than or equal to W, so CW bits never overflow.

Decomposition:
- Package seq_det_sched_pkg: state encoding constants (IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, DONE=4, 3 bits) and default N_REQ/W.
- Sub-module rr_arbiter: combinational. Inputs are req and the pointer; outputs are a one-hot grant and an index. It is instantiated once.
- The shift register, bit counter, hit counter and FSM stay in seq_det_scheduler.

Test Plan:
- Single req[0], data=8'b10001000, stub behavioural detector:
  - det_rst high one cycle after grant.
  - det_din sequence 1,0,0,0,1,0,0,0.
  - ack[0] 11 cycles after grant, hit_cnt=1.
- Single req[2], data=8'hFF -> ack[2] with hit_cnt=0; busy high for exactly 11 cycles.
- req=4'b1111 held continuously -> acks in order 0,1,2,3,0. Each grant is spaced W+4=12 cycles apart.
- req[0] data=8'b00001000, then req[1] data=8'b10000000 -> both hit_cnt=0. This proves that CLEAR isolates words, since without the clear the second word would give a hit.
- Reset asserted on the 4th SHIFT cycle -> next cycle state=IDLE, busy=0, no ack. A re-asserted req restarts with CLEAR and completes normally.
- Data changed and req dropped during SHIFT -> serialized bits match the word captured at grant, and ack is still issued.
